// File: rtl/uart_pkg.sv
// Shared types and defaults for the 8N1 UART receiver slice.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned CLK_FREQ_DEF = 100_000_000;
  localparam int unsigned BAUD_DEF     = 9600;
  localparam int unsigned OVS_DEF      = 16;
  localparam int unsigned DATA_BITS    = 8;

  // Even parity holds when data bits plus parity bit XOR to zero.
  function automatic logic even_par_ok(input logic [DATA_BITS-1:0] d, input logic p);
    return ~(^{d, p});
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-register-block handshake bundle; par_err exists only with UART_RX_PARITY_EN.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rx_rd;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_full;
  logic                 rx_busy;
  logic                 frame_err;
  logic                 rx_ovr;
`ifdef UART_RX_PARITY_EN
  logic                 par_err;
`endif

  modport master (
    input  rx_rd,
    output rx_data, rx_valid, rx_full, rx_busy, frame_err, rx_ovr
`ifdef UART_RX_PARITY_EN
    , output par_err
`endif
  );

  modport slave (
    output rx_rd,
    input  rx_data, rx_valid, rx_full, rx_busy, frame_err, rx_ovr
`ifdef UART_RX_PARITY_EN
    , input par_err
`endif
  );

endinterface

// File: rtl/uart_os_tick.sv
// Free-running oversample divider: one-clock tick every DIV clocks, restartable by clr_i.
module uart_os_tick #(
  parameter int unsigned DIV = 651
) (
  input  logic clk,
  input  logic arst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned    W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]   LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_d, tick_q;

  // Next count and a tick that lines up with the cycle the counter sits at LAST.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
    tick_d = (cnt_d == LAST) && !clr_i;
  end

  // Divider state.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and one-deep holding register.
// Optional even-parity frame format when UART_RX_PARITY_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = CLK_FREQ_DEF,
  parameter int unsigned BAUD     = BAUD_DEF,
  parameter int unsigned OVS      = OVS_DEF,
  parameter int unsigned DIV      = CLK_FREQ / (BAUD * OVS)
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        rx,
  uart_rx_if.master   bus
);

  localparam int unsigned    SW        = $clog2(OVS);
  localparam logic [SW-1:0]  SCNT_MID  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0]  SCNT_LAST = SW'(OVS - 1);
  localparam int unsigned    BW        = $clog2(DATA_BITS);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_BITS - 1);

  logic rx_meta_q, rx_s_q, rx_prev_q;
  logic start_edge_s, clr_s, tick_s, mid_s, end_s;

  uart_state_e          state_q, state_d;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;

  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic rx_valid_q, rx_valid_d, rx_full_q, rx_full_d;
  logic rx_busy_q, rx_busy_d, frame_err_q, frame_err_d;
  logic rx_ovr_q, rx_ovr_d;
  logic stop_s, good_stop_s, store_s;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, par_err_q, par_err_d;
`endif

  // Two-flop synchronizer plus previous-sample flop for start-edge detection.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign start_edge_s = rx_prev_q & ~rx_s_q;
  assign mid_s        = tick_s && (scnt_q == SCNT_MID);
  assign end_s        = tick_s && (scnt_q == SCNT_LAST);

  uart_os_tick #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .arst_n (arst_n),
    .clr_i  (clr_s),
    .tick_o (tick_s)
  );

  // FSM and bit-datapath state registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic; sampling points sit OVS/2 + k*OVS ticks after the start edge.
  always_comb begin
    state_d = state_q;
    scnt_d  = tick_s ? (scnt_q + SW'(1)) : scnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    clr_s   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_edge_s) begin
          state_d = START;
          clr_s   = 1'b1;
          scnt_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (mid_s) begin
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            scnt_d  = '0;
            bit_d   = '0;
          end
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (end_s) begin
          shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
          scnt_d  = '0;
          bit_d   = bit_q + BW'(1);
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (end_s) begin
          par_d   = rx_s_q;
          scnt_d  = '0;
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (end_s) begin
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output next values; a read coinciding with a new byte lets the new byte win.
  always_comb begin
    stop_s      = (state_q == STOP) && end_s;
    good_stop_s = stop_s && rx_s_q;
    frame_err_d = stop_s && !rx_s_q;
`ifdef UART_RX_PARITY_EN
    store_s     = good_stop_s && even_par_ok(shreg_q, par_q);
    par_err_d   = good_stop_s && !even_par_ok(shreg_q, par_q);
`else
    store_s     = good_stop_s;
`endif
    rx_valid_d  = store_s;
    rx_busy_d   = (state_d != IDLE);
    rx_data_d   = rx_data_q;
    rx_full_d   = rx_full_q;
    rx_ovr_d    = rx_ovr_q;
    if (store_s) begin
      rx_data_d = shreg_q;
      rx_full_d = 1'b1;
      rx_ovr_d  = bus.rx_rd ? 1'b0 : (rx_ovr_q | rx_full_q);
    end else if (bus.rx_rd && rx_full_q) begin
      rx_full_d = 1'b0;
      rx_ovr_d  = 1'b0;
    end else begin
      rx_full_d = rx_full_q;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_full_q   <= 1'b0;
      rx_busy_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_ovr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_full_q   <= rx_full_d;
      rx_busy_q   <= rx_busy_d;
      frame_err_q <= frame_err_d;
      rx_ovr_q    <= rx_ovr_d;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_full   = rx_full_q;
  assign bus.rx_busy   = rx_busy_q;
  assign bus.frame_err = frame_err_q;
  assign bus.rx_ovr    = rx_ovr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with an event scoreboard; DIV shrunk so frames stay short.
module tb_uart_rx;

  localparam int unsigned OVS = 16;
  localparam int unsigned DIV = 4;
  localparam int          PER = OVS * DIV;

  localparam int K_VALID = 0;
  localparam int K_FERR  = 1;
  localparam int K_PERR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic rx = 1'b1;
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  uart_rx_if bus ();

  uart_rx #(.OVS(OVS), .DIV(DIV)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .rx     (rx),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int kind, input logic [7:0] d);
    exp_t e;
    e.kind = kind;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_b, input int per);
    rx = 1'b0;
    wait_clks(per);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clks(per);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    wait_clks(per);
`endif
    rx = stop_b;
    wait_clks(per);
  endtask

  task automatic rd_pulse();
    @(negedge clk);
    bus.rx_rd = 1'b1;
    @(negedge clk);
    bus.rx_rd = 1'b0;
  endtask

  // Monitor: every output event is matched against the head of the scoreboard.
  always @(negedge clk) begin
    int   obs;
    exp_t e;
    logic ev;
    ev = arst_n && (bus.rx_valid || bus.frame_err);
    obs = bus.rx_valid ? K_VALID : K_FERR;
`ifdef UART_RX_PARITY_EN
    if (arst_n && bus.par_err) begin
      ev = 1'b1;
      obs = K_PERR;
    end
`endif
    if (ev) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: got kind %0d data %0h expected no event", obs, bus.rx_data);
      end else begin
        e = sb_q.pop_front();
        chk("event_kind", obs, e.kind);
        if (e.kind == K_VALID) chk("rx_data", {24'd0, bus.rx_data}, {24'd0, e.data});
      end
    end
  end

  initial begin
    bus.rx_rd = 1'b0;
    wait_clks(3);
    chk("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
    chk("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    chk("rst_rx_full", {31'd0, bus.rx_full}, 32'd0);
    chk("rst_rx_busy", {31'd0, bus.rx_busy}, 32'd0);
    chk("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    chk("rst_rx_ovr", {31'd0, bus.rx_ovr}, 32'd0);
    arst_n = 1'b1;
    wait_clks(2 * PER);

    // T1: clean byte
    push_exp(K_VALID, 8'hA5);
    send_byte(8'hA5, 1'b1, PER);
    chk("t1_full", {31'd0, bus.rx_full}, 32'd1);
    chk("t1_ovr", {31'd0, bus.rx_ovr}, 32'd0);
    chk("t1_busy_idle", {31'd0, bus.rx_busy}, 32'd0);
    rd_pulse();
    chk("t1_full_after_rd", {31'd0, bus.rx_full}, 32'd0);
    wait_clks(PER);

    // T2: short low glitch
    rx = 1'b0;
    wait_clks(3 * DIV);
    chk("t2_busy_in_start", {31'd0, bus.rx_busy}, 32'd1);
    rx = 1'b1;
    wait_clks(40);
    chk("t2_busy_dropped", {31'd0, bus.rx_busy}, 32'd0);
    chk("t2_full", {31'd0, bus.rx_full}, 32'd0);
    wait_clks(PER);

    // T3: framing error, line stays low, then recovers
    push_exp(K_FERR, 8'h00);
    send_byte(8'h3C, 1'b0, PER);
    chk("t3_data_kept", {24'd0, bus.rx_data}, 32'hA5);
    chk("t3_full_kept", {31'd0, bus.rx_full}, 32'd0);
    wait_clks(2 * PER);
    chk("t3_busy_low_line", {31'd0, bus.rx_busy}, 32'd0);
    rx = 1'b1;
    wait_clks(PER);
    push_exp(K_VALID, 8'h55);
    send_byte(8'h55, 1'b1, PER);
    chk("t3_full_55", {31'd0, bus.rx_full}, 32'd1);
    rd_pulse();
    wait_clks(PER);

    // T4: overrun
    push_exp(K_VALID, 8'h11);
    send_byte(8'h11, 1'b1, PER);
    push_exp(K_VALID, 8'h22);
    send_byte(8'h22, 1'b1, PER);
    chk("t4_data", {24'd0, bus.rx_data}, 32'h22);
    chk("t4_ovr", {31'd0, bus.rx_ovr}, 32'd1);
    chk("t4_full", {31'd0, bus.rx_full}, 32'd1);
    rd_pulse();
    chk("t4_full_cleared", {31'd0, bus.rx_full}, 32'd0);
    chk("t4_ovr_cleared", {31'd0, bus.rx_ovr}, 32'd0);
    wait_clks(PER);

    // T5: back-to-back frames at -1.6% and +1.6% bit period, left unread
    push_exp(K_VALID, 8'h00);
    send_byte(8'h00, 1'b1, PER - 1);
    push_exp(K_VALID, 8'hFF);
    send_byte(8'hFF, 1'b1, PER + 1);
    chk("t5_data", {24'd0, bus.rx_data}, 32'hFF);
    chk("t5_ovr", {31'd0, bus.rx_ovr}, 32'd1);
    wait_clks(PER);

    // T6: reset in the middle of DATA for 0x81
    rx = 1'b0;
    wait_clks(PER);
    rx = 1'b1;
    wait_clks(PER);
    rx = 1'b0;
    wait_clks(PER);
    chk("t6_busy_mid", {31'd0, bus.rx_busy}, 32'd1);
    arst_n = 1'b0;
    #1;
    chk("t6_rst_data", {24'd0, bus.rx_data}, 32'd0);
    chk("t6_rst_full", {31'd0, bus.rx_full}, 32'd0);
    chk("t6_rst_busy", {31'd0, bus.rx_busy}, 32'd0);
    chk("t6_rst_ovr", {31'd0, bus.rx_ovr}, 32'd0);
    wait_clks(3);
    rx = 1'b1;
    arst_n = 1'b1;
    wait_clks(2 * PER);
    push_exp(K_VALID, 8'h81);
    send_byte(8'h81, 1'b1, PER);
    chk("t6_full", {31'd0, bus.rx_full}, 32'd1);
    rd_pulse();

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit: byte dropped, par_err pulses.
    wait_clks(PER);
    par_flip = 1'b1;
    push_exp(K_PERR, 8'h00);
    send_byte(8'h81, 1'b1, PER);
    par_flip = 1'b0;
    chk("par_full_unchanged", {31'd0, bus.rx_full}, 32'd0);
`endif

    wait_clks(2 * PER);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. Companion to the existing 8N1 transmitter.
- Samples the asynchronous serial line at 16x the baud rate and reassembles LSB-first bytes.
- Presents each byte through a one-deep holding register with a read handshake.
- Sits between the pad-side rx line and the APB register block. The APB side reads the data and clears the full flag.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- OVS, 16, oversampling factor. Must be a power of 2, ≥8.
- DIV, CLK_FREQ/(BAUD*OVS), clocks per oversample tick. The default evaluates to 651. Must be ≥2.

Ports:
- clk  in  1  system clock.
- arst_n  in  1  reset, asynchronous, active-low.
- rx  in  1  asynchronous serial input. Idles high.
- rx_rd  in  1  one-cycle pulse that consumes the held byte.
- rx_data  out  8  last good byte. Held until the next good byte.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- rx_full  out  1  set with rx_valid, cleared by rx_rd.
- rx_busy  out  1  high in any state other than IDLE.
- frame_err  out  1  one-cycle pulse when the stop bit samples 0.
- rx_ovr  out  1  sticky overrun. Cleared by rx_rd.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, rx_full=0, rx_busy=0, frame_err=0, rx_ovr=0. State=IDLE. Both synchronizer flops=1.
- rx passes through a 2-flop synchronizer to give rx_s. All decisions use rx_s.
- Tick divider counts 0..DIV-1 and issues a one-clock tick at DIV-1.
- The divider and the sample counter scnt (0..OVS-1) are cleared when a start edge is detected. This aligns sampling to the edge.
- IDLE: a falling edge (previous rx_s=1, current rx_s=0) moves to START and clears the divider and scnt.
- START: on the tick where scnt=OVS/2-1 (mid-bit), branch on rx_s.
  - rx_s=1: glitch. Return to IDLE with no outputs.
  - rx_s=0: clear scnt and go to DATA with bit index 0.
- DATA: on each tick where scnt=OVS-1, shift rx_s into shreg[7] (shift right, so LSB first) and clear scnt.
  - After the 8th bit, go to STOP.
  - Sampling therefore stays mid-bit: OVS/2 + k*OVS ticks after the edge.
- STOP: on the tick where scnt=OVS-1, sample rx_s.
  - rx_s=1: next clock, rx_data<=shreg and rx_valid pulses. If rx_full was already 1, rx_ovr<=1; otherwise rx_full<=1. rx_data is overwritten in both cases.
  - rx_s=0: frame_err pulses next clock. rx_data, rx_valid and rx_full are unchanged.
  - Either way, return to IDLE.
- After a framing error or break, a new start requires rx_s to go high first, since the edge detector needs previous=1.
- Return to IDLE happens mid-stop-bit, so back-to-back frames are accepted.
- rx_rd in the same cycle as a new rx_valid: the new byte wins. rx_full stays 1, rx_ovr is cleared, and no overrun is flagged.
- rx_rd while rx_full=0 has no effect.
- Latency: rx_valid occurs 2 sync cycles + (9*OVS + OVS/2)*DIV + ~2 clocks after the start falling edge.
- arst_n asserted mid-frame aborts immediately to reset values. The partial byte is discarded.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP. It samples one bit at scnt=OVS-1.
  - Even parity is checked: XOR of the 8 data bits and the parity bit must be 0.
  - Added output par_err (1 bit, reset 0). It pulses at the same time as rx_valid would.
  - On a parity mismatch the byte is discarded: no rx_valid, no rx_full change.
- Undefined:
  - 8N1 only. The PARITY state and the par_err port do not exist.

Decomposition:
- Package uart_pkg:
  - state enum IDLE/START/DATA/PARITY/STOP (2–3 bits);
  - default CLK_FREQ/BAUD constants;
  - OVS default;
  - DATA_BITS=8.
- One natural sub-module: uart_os_tick. It holds the free-running DIV divider with synchronous clear and emits a one-clock tick.

Test Plan:
1. Send 0xA5, 8N1, at exact baud → rx_valid pulses once, rx_data=0xA5, rx_full=1, frame_err=0.
2. Drive a low glitch of 3*DIV clocks in IDLE → no state change beyond START, rx_busy drops, no outputs.
3. Send 0x3C with the stop bit forced 0 → frame_err pulses, rx_data keeps its previous value, rx_full unchanged. The next frame 0x55 is received only after the line returns high.
4. Send 0x11 then 0x22 with no rx_rd → second rx_valid, rx_data=0x22, rx_ovr=1. Then rx_rd → rx_full=0, rx_ovr=0.
5. Send 0xFF and 0x00 back-to-back at BAUD±2% → both bytes received correctly.
6. Assert arst_n mid-DATA of 0x81 → all outputs reset. Send 0x81 afterwards → received correctly. With UART_RX_PARITY_EN, a wrong parity bit gives par_err=1 and no rx_valid.
